prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Byte-stream program loader: the writer side of the core's instruction memory.
//  Takes a little-endian byte stream from a host/UART bridge and assembles 32-bit RV32I words.
//  Writes the words into instruction memory starting at word address 0.
//  Holds alphacore in reset until the image and its trailing checksum have been received and verified.
// PARAMETERS
//  DEPTH   256  instruction memory depth in 32-bit words
//  ADDR_W  8    word address width, = clog2(DEPTH)
// PORTS
//  clk          in   1         single system clock, rising edge
//  rst_n        in   1         asynchronous active-low reset
//  start        in   1         pulse: begin a load; len_words sampled on the same edge
//  len_words    in   ADDR_W+1  image length in words, legal range 1..DEPTH
//  byte_valid   in   1         byte_data valid
//  byte_data    in   8         stream byte
//  byte_ready   out  1         loader accepts a byte this cycle
//  mem_we       out  1         instruction memory write strobe, one cycle per word
//  mem_addr     out  ADDR_W    word address
//  mem_wdata    out  32        assembled word
//  core_rst_n   out  1         0 = core held in reset; 1 only in DONE
//  busy         out  1         1 in LOAD or CHECK
//  done         out  1         1 in DONE
//  err          out  1         1 in ERR
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, including core_rst_n, mem_we, mem_addr, mem_wdata.
//   Word index, byte index and sum all cleared.
//  Byte handshake: a byte is accepted on an edge where byte_valid && byte_ready.
//   byte_ready = 1 only in LOAD and CHECK. The loader never stalls inside those states.
//  FSM: IDLE, LOAD, CHECK, DONE, ERR.
//   IDLE/DONE/ERR + start:
//    - len_words in 1..DEPTH -> LOAD, with counters and sum cleared and core_rst_n = 0.
//    - otherwise -> ERR.
//   LOAD: bytes 0..3 of each word go to bits [7:0], [15:8], [23:16], [31:24] (little-endian).
//    On the edge accepting byte 3, the next cycle shows mem_we = 1 for exactly one cycle.
//    In that cycle mem_addr = word index and mem_wdata = the assembled word.
//    Same edge: sum <= sum + word (mod 2^32) and word index increments.
//    After word len_words-1 -> CHECK.
//   CHECK: accept 4 bytes, assembled little-endian into a 32-bit trailer.
//    On the 4th byte: trailer == sum -> DONE, otherwise -> ERR.
//   DONE: core_rst_n = 1 and done = 1, held until the next start. core_rst_n returns to 0 on that start.
//   ERR: err = 1, core_rst_n = 0, held until the next start.
//  start while in LOAD or CHECK is ignored.
//  byte_valid in IDLE/DONE/ERR is ignored; no byte is accepted.
//  Latency: last trailer byte accept edge -> done/err visible the next cycle.
//  Address wrap: impossible by construction (len_words <= DEPTH). mem_addr never exceeds DEPTH-1.
//  Reset mid-operation: immediate return to IDLE with core_rst_n = 0. The partial image in memory is not scrubbed.
//  mem_we is never asserted outside the cycle following a word-completing byte.
// STRUCTURE
//  Shared package alpha_pkg:
//   - loader state encoding as localparams LD_IDLE..LD_ERR
//   - XLEN = 32
//   - IMEM_DEPTH = 256
//  Sub-module word_asm: byte-lane shifter plus 2-bit byte index.
//   Outputs word and word_ok pulse; reused for the CHECK trailer.
//  FSM, counters and checksum adder live in prog_loader.
// TESTING
//  1) len_words = 1; bytes b3 06 00 00, then trailer b3 06 00 00.
//     -> mem_we @ addr 0, data 0x000006b3; done = 1; core_rst_n = 1.
//  2) len_words = 2 with words 0x00600713 and 0x00e6a023, trailer 0x00e6a023 + 0x00600713 = 0x0146a736.
//     -> writes at addr 0 and addr 1; done = 1.
//  3) Same stream as test 2 but trailer 0x0146a737.
//     -> err = 1, core_rst_n stays 0, done = 0.
//  4) start with len_words = 0, then again with len_words = 257.
//     -> err = 1 the next cycle each time; byte_ready = 0; no mem_we.
//  5) len_words = 256 with random byte_valid gaps.
//     -> 256 writes, addr 0..255 in order; done = 1; never a mem_we without a completed word.
//  6) rst_n low after 6 of 8 bytes of a 2-word load.
//     -> IDLE, all outputs 0.
//     A following start with len_words = 1 loads cleanly to addr 0.

Source files
------------

// File: rtl/alpha_pkg.sv
// Shared loader definitions: datapath width, instruction memory geometry and
// the loader state encoding.
package alpha_pkg;
    localparam int XLEN       = 32;
    localparam int IMEM_DEPTH = 256;
    localparam int IMEM_AW    = $clog2(IMEM_DEPTH);

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_LOAD  = 3'd1,
        LD_CHECK = 3'd2,
        LD_DONE  = 3'd3,
        LD_ERR   = 3'd4
    } ld_state_t;
endpackage

// File: rtl/prog_loader_if.sv
// Host byte stream plus instruction-memory write port and loader status.
// The host/bench drives through master; the loader sits on slave.
interface prog_loader_if
    import alpha_pkg::*;
#(
    parameter int ADDR_W = IMEM_AW,
    parameter int DATA_W = XLEN
);
    logic              start;
    logic [ADDR_W:0]   len_words;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              core_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, len_words, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata, core_rst_n, busy, done, err
    );

    modport slave (
        input  start, len_words, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata, core_rst_n, busy, done, err
    );
endinterface

// File: rtl/prog_loader_word_asm.sv
// Little-endian word assembler: collects three bytes in lanes and presents the
// full word combinationally together with the fourth byte.
module word_asm
    import alpha_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            byte_en_i,
    input  logic [7:0]      byte_i,
    output logic [XLEN-1:0] word_o,
    output logic            word_ok_o
);
    logic [1:0] idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 2'd0;
        end else if (clr_i) begin
            idx_q <= 2'd0;
        end else if (byte_en_i) begin
            idx_q <= idx_q + 2'd1;
        end
    end

    // Lane 3 is never stored: it is the byte arriving on the completing edge.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] byte_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    byte_q <= 8'h00;
                end else if (clr_i) begin
                    byte_q <= 8'h00;
                end else if (byte_en_i && idx_q == 2'(gi)) begin
                    byte_q <= byte_i;
                end
            end
        end
    endgenerate

    assign word_o    = {byte_i, g_lane[2].byte_q, g_lane[1].byte_q, g_lane[0].byte_q};
    assign word_ok_o = byte_en_i && (idx_q == 2'd3);
endmodule

// File: rtl/prog_loader.sv
// Program loader: streams words into instruction memory, verifies the trailing
// checksum and releases the core from reset only after a clean load.
module prog_loader
    import alpha_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
)
(
    input  logic         clk,
    input  logic         rst_n,
    prog_loader_if.slave bus
);
    ld_state_t         state_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   widx_q;
    logic [XLEN-1:0]   sum_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [XLEN-1:0]   mem_wdata_q;
    logic              core_rst_n_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              accept;
    logic              start_ok;
    logic              len_legal;
    logic [XLEN-1:0]   asm_word;
    logic              asm_ok;

    // busy_q doubles as byte_ready: high exactly in LOAD and CHECK.
    assign accept    = bus.byte_valid && busy_q;
    assign start_ok  = bus.start && !busy_q;
    assign len_legal = (bus.len_words != '0) && (bus.len_words <= (ADDR_W+1)'(DEPTH));

    word_asm u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (start_ok),
        .byte_en_i (accept),
        .byte_i    (bus.byte_data),
        .word_o    (asm_word),
        .word_ok_o (asm_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LD_IDLE;
            len_q        <= '0;
            widx_q       <= '0;
            sum_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                LD_IDLE, LD_DONE, LD_ERR: begin
                    if (bus.start) begin
                        core_rst_n_q <= 1'b0;
                        done_q       <= 1'b0;
                        widx_q       <= '0;
                        sum_q        <= '0;
                        if (len_legal) begin
                            state_q <= LD_LOAD;
                            len_q   <= bus.len_words;
                            busy_q  <= 1'b1;
                            err_q   <= 1'b0;
                        end else begin
                            state_q <= LD_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                LD_LOAD: begin
                    if (asm_ok) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= widx_q[ADDR_W-1:0];
                        mem_wdata_q <= asm_word;
                        sum_q       <= sum_q + asm_word;
                        widx_q      <= widx_q + 1'b1;
                        if (widx_q == len_q - 1'b1) begin
                            state_q <= LD_CHECK;
                        end
                    end
                end
                LD_CHECK: begin
                    if (asm_ok) begin
                        busy_q <= 1'b0;
                        if (asm_word == sum_q) begin
                            state_q      <= LD_DONE;
                            done_q       <= 1'b1;
                            core_rst_n_q <= 1'b1;
                        end else begin
                            state_q <= LD_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= LD_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_ready = busy_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.core_rst_n = core_rst_n_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a queue of expected memory writes and a
// plain arithmetic checksum model decide every expected value.
module tb_prog_loader;
    import alpha_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_loader_if bus ();

    prog_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    int          total = 0;
    int          bad   = 0;
    wr_t         exp_q[$];
    logic [31:0] wq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the oldest outstanding completed word.
    always @(negedge clk) begin
        if (rst_n && bus.mem_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("spurious_we", {31'd0, bus.mem_we}, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("we_addr", {24'd0, bus.mem_addr}, {24'd0, e.addr});
                check("we_data", bus.mem_wdata, e.data);
                $display("write addr=%0d data=0x%08h", bus.mem_addr, bus.mem_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        bus.start     = 1'b1;
        bus.len_words = 9'(len);
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int gap;
        gap = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
        bus.byte_valid = 1'b0;
        repeat (gap) tick();
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        tick();
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input bit is_data, input int idx);
        for (int i = 0; i < 4; i++) begin
            if (is_data && i == 3) exp_q.push_back('{addr: 8'(idx), data: w});
            send_byte(w[8*i +: 8], gap);
        end
    endtask

    task automatic check_status(input string tag, input bit d, input bit e, input bit crn, input bit bsy);
        check({tag, "_done"}, {31'd0, bus.done}, {31'd0, d});
        check({tag, "_err"}, {31'd0, bus.err}, {31'd0, e});
        check({tag, "_core_rst_n"}, {31'd0, bus.core_rst_n}, {31'd0, crn});
        check({tag, "_busy"}, {31'd0, bus.busy}, {31'd0, bsy});
        check({tag, "_byte_ready"}, {31'd0, bus.byte_ready}, {31'd0, bsy});
    endtask

    // Loads the words in wq, then sends trailer = checksum + delta.
    task automatic run_load(input string tag, input logic [31:0] delta, input int gap, input bit mid_start);
        logic [31:0] sum;
        logic [31:0] trailer;
        sum = 32'd0;
        do_start(wq.size());
        check_status({tag, "_start"}, 1'b0, 1'b0, 1'b0, 1'b1);
        foreach (wq[i]) begin
            send_word(wq[i], gap, 1'b1, i);
            sum = sum + wq[i];
            if (mid_start && i == 0) begin
                do_start(0);
                check_status({tag, "_ignored_start"}, 1'b0, 1'b0, 1'b0, 1'b1);
            end
        end
        trailer = sum + delta;
        send_word(trailer, gap, 1'b0, 0);
        check_status(tag, (delta == 0), (delta != 0), (delta == 0), 1'b0);
        tick();
        check({tag, "_pending_writes"}, exp_q.size(), 32'd0);
        $display("load %s len=%0d sum=0x%08h trailer=0x%08h done=%0b err=%0b",
                 tag, wq.size(), sum, trailer, bus.done, bus.err);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_we"}, {31'd0, bus.mem_we}, 32'd0);
        check({tag, "_mem_addr"}, {24'd0, bus.mem_addr}, 32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        check_status(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic bad_len(input int len);
        do_start(len);
        check_status($sformatf("badlen%0d", len), 1'b0, 1'b1, 1'b0, 1'b0);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hA5;
        repeat (6) tick();
        bus.byte_valid = 1'b0;
        check($sformatf("badlen%0d_err_held", len), {31'd0, bus.err}, 32'd1);
        $display("start len=%0d err=%0b", len, bus.err);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.len_words  = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Single word image.
        wq = {};
        wq.push_back(32'h000006b3);
        run_load("t1", 32'd0, 0, 1'b0);

        // Two words, with an ignored start in the middle.
        wq = {};
        wq.push_back(32'h00600713);
        wq.push_back(32'h00e6a023);
        run_load("t2", 32'd0, 2, 1'b1);

        // Same stream, checksum off by one.
        run_load("t3", 32'd1, 1, 1'b0);

        bad_len(0);
        bad_len(257);

        // Random lengths and contents, some with corrupted trailers.
        for (int k = 0; k < 4; k++) begin
            int n;
            n  = $urandom_range(20, 1);
            wq = {};
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            run_load($sformatf("rnd%0d", k), (k % 2 == 1) ? $urandom | 32'd1 : 32'd0, 3, 1'b0);
        end

        // Full-depth image with random valid gaps.
        wq = {};
        for (int i = 0; i < IMEM_DEPTH; i++) wq.push_back($urandom);
        run_load("t5", 32'd0, 2, 1'b0);

        // Reset after 6 of 8 bytes of a two-word load.
        wq = {};
        wq.push_back(32'h11223344);
        wq.push_back(32'h55667788);
        do_start(2);
        send_word(wq[0], 0, 1'b1, 0);
        send_byte(8'h88, 0);
        send_byte(8'h77, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        check("midreset_pending", exp_q.size(), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        wq = {};
        wq.push_back(32'hdeadbeef);
        run_load("t6", 32'd0, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
